// File: rtl/jts16_busresp.sv
// 68000 bus responder for one decoded region: captures a CPU cycle, runs one
// request/acknowledge memory transaction and answers with DTACKn or BERRn.
module jts16_busresp #(
  parameter int AW      = 17,
  parameter int MINWAIT = 1,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cpu_cen,
  input  logic          cpu_cenb,
  input  logic          cs,
  input  logic          ASn,
  input  logic          UDSn,
  input  logic          LDSn,
  input  logic          RnW,
  input  logic [AW:1]   A,
  input  logic [15:0]   cpu_dout,
  output logic [15:0]   dout,
  output logic          DTACKn,
  output logic          BERRn,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_wmask,
  input  logic [15:0]   mem_dout,
  input  logic          mem_ok
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_MEM, ST_WAIT, ST_ACK, ST_BERR, ST_DRAIN
  } state_t;

  localparam logic [3:0] MW_LIM = 4'(MINWAIT);
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t        state_reg, state_next;
  logic          dtackn_reg, dtackn_next;
  logic          berrn_reg, berrn_next;
  logic          req_reg, req_next;
  logic          we_reg, we_next;
  logic [15:0]   dout_reg, dout_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [15:0]   din_reg, din_next;
  logic [1:0]    wmask_reg, wmask_next;
  logic [3:0]    wait_cnt_reg, wait_cnt_next;
  logic [7:0]    to_cnt_reg, to_cnt_next;
  logic          armed_reg, armed_next;
  logic          start;

  // armed_reg: ASn has been seen high since the last captured cycle
  assign start = cpu_cen & cs & ~ASn & (~UDSn | ~LDSn) & armed_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= ST_IDLE;
      dtackn_reg   <= 1'b1;
      berrn_reg    <= 1'b1;
      req_reg      <= 1'b0;
      we_reg       <= 1'b0;
      dout_reg     <= 16'hffff;
      addr_reg     <= '0;
      din_reg      <= '0;
      wmask_reg    <= '0;
      wait_cnt_reg <= '0;
      to_cnt_reg   <= '0;
      armed_reg    <= 1'b1;
    end else begin
      state_reg    <= state_next;
      dtackn_reg   <= dtackn_next;
      berrn_reg    <= berrn_next;
      req_reg      <= req_next;
      we_reg       <= we_next;
      dout_reg     <= dout_next;
      addr_reg     <= addr_next;
      din_reg      <= din_next;
      wmask_reg    <= wmask_next;
      wait_cnt_reg <= wait_cnt_next;
      to_cnt_reg   <= to_cnt_next;
      armed_reg    <= armed_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    dtackn_next   = dtackn_reg;
    berrn_next    = berrn_reg;
    req_next      = req_reg;
    we_next       = we_reg;
    dout_next     = dout_reg;
    addr_next     = addr_reg;
    din_next      = din_reg;
    wmask_next    = wmask_reg;
    wait_cnt_next = wait_cnt_reg;
    to_cnt_next   = to_cnt_reg;
    armed_next    = armed_reg | ASn;

    if (cpu_cen && (state_reg == ST_MEM || state_reg == ST_WAIT) && wait_cnt_reg != 4'hf)
      wait_cnt_next = wait_cnt_reg + 4'd1;
    if (cpu_cen && state_reg == ST_MEM && to_cnt_reg != 8'hff)
      to_cnt_next = to_cnt_reg + 8'd1;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          addr_next     = A;
          din_next      = cpu_dout;
          wmask_next    = {~UDSn, ~LDSn};
          we_next       = ~RnW;
          req_next      = 1'b1;
          wait_cnt_next = '0;
          to_cnt_next   = '0;
          armed_next    = 1'b0;
          state_next    = ST_MEM;
        end
      end
      ST_MEM: begin
        // An abandoned cycle still lets the memory finish; its data is dropped
        if (ASn) begin
          if (mem_ok) begin
            req_next   = 1'b0;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DRAIN;
          end
        end else if (mem_ok) begin
          req_next = 1'b0;
          if (!we_reg) dout_next = mem_dout;
          state_next = ST_WAIT;
        end else if (cpu_cenb && to_cnt_reg >= TO_LIM) begin
          berrn_next = 1'b0;
          state_next = ST_BERR;
        end
      end
      ST_WAIT: begin
        if (ASn) begin
          state_next = ST_IDLE;
        end else if (cpu_cenb && wait_cnt_reg >= MW_LIM) begin
          dtackn_next = 1'b0;
          state_next  = ST_ACK;
        end
      end
      ST_ACK: begin
        if (ASn) begin
          dtackn_next = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_BERR: begin
        if (mem_ok) req_next = 1'b0;
        if (ASn) begin
          berrn_next = 1'b1;
          state_next = (req_reg && !mem_ok) ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (mem_ok) begin
          req_next   = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign dout      = dout_reg;
  assign DTACKn    = dtackn_reg;
  assign BERRn     = berrn_reg;
  assign mem_req   = req_reg;
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_din   = din_reg;
  assign mem_wmask = wmask_reg;

endmodule
